pkt_out_arbiter: RTL and testbench

Packet-atomic round-robin arbiter that shares the single 16-bit write port of `output_fifo` among `N_SRC` result sources inside the `PKT_COMM_CLK` domain. Each source presents first-word-fall-through 16-bit words with a last-word flag. The arbiter grants one source at a time and holds the grant until that source's last word is written, so packets never interleave. It also reports an idle indication for the clock-gating logic.

---
 rtl/pkt_arb_pkg.sv | 13 +
 rtl/pkt_out_arbiter_rr_pick.sv | 28 ++
 rtl/pkt_out_arbiter.sv | 112 +++++++++++
 tb/tb_pkt_out_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_arb_pkg.sv
// Shared types and constants for the packet-atomic output arbiter.
// The S_ERR state is used only when PKT_ARB_WATCHDOG_EN is defined.
package pkt_arb_pkg;

  localparam int unsigned PKT_WORD_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_ERR  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/pkt_out_arbiter_rr_pick.sv
// Combinational round-robin pick: the first requester strictly after i_ptr,
// wrapping around; o_any flags that at least one request is present.
module rr_pick
  import pkt_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_k;

  // Scan from the farthest candidate down so the nearest one after i_ptr wins.
  always_comb begin
    o_idx = '0;
    o_any = |i_req;
    w_k   = '0;
    for (int unsigned i = N; i > 0; i--) begin
      w_k = IW'((32'(i_ptr) + i) % N);
      if (i_req[w_k]) o_idx = w_k;
    end
  end

endmodule

// File: rtl/pkt_out_arbiter.sv
// Packet-atomic round-robin arbiter feeding the output_fifo write port.
// Optional stall watchdog is compiled in with `define PKT_ARB_WATCHDOG_EN.
module pkt_out_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int unsigned N_SRC   = 4,
  parameter int unsigned WD_BITS = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [PKT_WORD_W*N_SRC-1:0]   src_dout,
  input  logic [N_SRC-1:0]              src_last,
  input  logic [N_SRC-1:0]              src_empty,
  output logic [N_SRC-1:0]              src_rd_en,
  output logic [PKT_WORD_W-1:0]         dout,
  output logic                          wr_en,
  input  logic                          full,
  output logic [$clog2(N_SRC)-1:0]      grant,
  output logic                          arb_idle,
  output logic                          arb_err
);

  localparam int unsigned GW = $clog2(N_SRC);

  arb_state_t    r_state, w_next;
  logic [GW-1:0] r_grant, r_rr_ptr, w_pick;
  logic [N_SRC-1:0] w_req;
  logic          w_any, w_xfer, w_last_xfer, w_wd_fire, r_arb_idle;

  assign w_req = ~src_empty;

  rr_pick #(.N(N_SRC), .IW(GW)) u_pick (
    .i_req (w_req),
    .i_ptr (r_rr_ptr),
    .o_idx (w_pick),
    .o_any (w_any)
  );

  assign w_xfer      = (r_state == S_XFER) & ~src_empty[r_grant] & ~full;
  assign w_last_xfer = w_xfer & src_last[r_grant];

`ifdef PKT_ARB_WATCHDOG_EN
  localparam logic [WD_BITS-1:0] WD_LAST = ~WD_BITS'(1);

  logic [WD_BITS-1:0] r_wd_cnt;
  logic               w_wd_tick, r_arb_err;

  // Full-stalled cycles are excluded: the sink, not the source, is slow.
  assign w_wd_tick = (r_state == S_XFER) & src_empty[r_grant] & ~full;
  assign w_wd_fire = w_wd_tick & (r_wd_cnt == WD_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wd_cnt  <= '0;
      r_arb_err <= 1'b0;
    end else begin
      if (r_state != S_XFER || w_xfer) r_wd_cnt <= '0;
      else if (w_wd_tick)              r_wd_cnt <= r_wd_cnt + 1'b1;
      if (w_next == S_ERR)             r_arb_err <= 1'b1;
    end
  end

  assign arb_err = r_arb_err;
`else
  assign w_wd_fire = 1'b0;
  assign arb_err   = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_XFER;
      S_XFER: begin
        if (w_last_xfer)    w_next = S_IDLE;
        else if (w_wd_fire) w_next = S_ERR;
      end
      S_ERR:   w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    src_rd_en = '0;
    wr_en     = 1'b0;
    dout      = src_dout[r_grant*PKT_WORD_W +: PKT_WORD_W];
    if (w_xfer) begin
      src_rd_en[r_grant] = 1'b1;
      wr_en              = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_grant    <= '0;
      r_rr_ptr   <= GW'(N_SRC - 1);
      r_arb_idle <= 1'b1;
    end else begin
      if (r_state == S_IDLE && w_any) r_grant <= w_pick;
      if (w_last_xfer)                r_rr_ptr <= r_grant;
      r_arb_idle <= (w_next == S_IDLE) & (&src_empty);
    end
  end

  assign grant    = r_grant;
  assign arb_idle = r_arb_idle;

endmodule

// File: tb/tb_pkt_out_arbiter.sv
// Scoreboard bench for pkt_out_arbiter: FWFT source models, expected-word queue
// and a negedge monitor; watchdog expectations follow PKT_ARB_WATCHDOG_EN.
module tb_pkt_out_arbiter;

  localparam int unsigned N = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        full = 1'b0;
  logic [63:0] src_dout;
  logic [3:0]  src_last, src_empty, src_rd_en;
  logic [15:0] dout;
  logic        wr_en;
  logic [1:0]  grant;
  logic        arb_idle, arb_err;

  pkt_out_arbiter #(.N_SRC(4), .WD_BITS(4)) dut (
    .CLK(CLK), .RST(RST), .src_dout(src_dout), .src_last(src_last),
    .src_empty(src_empty), .src_rd_en(src_rd_en), .dout(dout), .wr_en(wr_en),
    .full(full), .grant(grant), .arb_idle(arb_idle), .arb_err(arb_err)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [15:0] d; logic l; } sw_t;
  typedef struct { int unsigned s; logic [15:0] d; } ex_t;

  sw_t sq[N][$];
  ex_t exp_q[$];
  int  n_chk = 0;
  int  n_err = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
    end
  endfunction

  function automatic void src_push(int unsigned k, logic [15:0] d, logic l);
    sq[k].push_back('{d: d, l: l});
  endfunction

  function automatic void exp_push(int unsigned k, logic [15:0] d);
    exp_q.push_back('{s: k, d: d});
  endfunction

  // Source models: only this process writes the src_* signals.
  function automatic void drive();
    for (int k = 0; k < N; k++) begin
      if (sq[k].size() == 0) begin
        src_empty[k]       = 1'b1;
        src_last[k]        = 1'b0;
        src_dout[16*k +: 16] = 16'hDEAD;
      end else begin
        src_empty[k]       = 1'b0;
        src_last[k]        = sq[k][0].l;
        src_dout[16*k +: 16] = sq[k][0].d;
      end
    end
  endfunction

  logic [3:0] snap;
  sw_t        popped;
  initial begin
    drive();
    forever begin
      @(negedge CLK);
      snap = src_rd_en;
      @(posedge CLK);
      #1;
      for (int k = 0; k < N; k++)
        if (snap[k] && sq[k].size() > 0) popped = sq[k].pop_front();
      drive();
      #3;
      drive();
    end
  end

  // Monitor: every written word must be the next expected one.
  ex_t        mon_e;
  logic [3:0] mon_oh;
  always @(negedge CLK) begin
    chk("wr_en_eq_or_rd_en", 32'(wr_en), 32'(|src_rd_en));
    if (full) chk("full_blocks_write", 32'(wr_en), 32'd0);
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_write: got dout %0h grant %0d, required no write at %0t",
                 dout, grant, $time);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_oh = 4'b0001 << mon_e.s;
        chk("dout", 32'(dout), 32'(mon_e.d));
        chk("rd_en_onehot", 32'(src_rd_en), 32'(mon_oh));
        chk("grant_on_write", 32'(grant), mon_e.s);
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #3;
  endtask

  task automatic reset_dut();
    RST  = 1'b1;
    full = 1'b0;
    for (int k = 0; k < N; k++) sq[k].delete();
    exp_q.delete();
    cyc();
    RST = 1'b0;
    cyc();
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) cyc();
    chk("drain_timeout", exp_q.size(), 32'd0);
    repeat (2) cyc();
  endtask

  int w_cnt, last_n;

  initial begin
    RST = 1'b1;
    repeat (3) cyc();
    RST = 1'b0;
    cyc();
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_arb_idle", 32'(arb_idle), 32'd1);
    chk("reset_arb_err", 32'(arb_err), 32'd0);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_rd_en", 32'(src_rd_en), 32'd0);

    // Source 2 alone, three words.
    src_push(2, 16'h1111, 1'b0); exp_push(2, 16'h1111);
    src_push(2, 16'h2222, 1'b0); exp_push(2, 16'h2222);
    src_push(2, 16'h3333, 1'b1); exp_push(2, 16'h3333);
    cyc();
    chk("t1_grant", 32'(grant), 32'd2);
    chk("t1_first_wr", 32'(wr_en), 32'd1);
    cyc();
    cyc();
    chk("t1_third_wr", 32'(wr_en), 32'd1);
    cyc();
    chk("t1_idle_plus1", 32'(arb_idle), 32'd0);
    cyc();
    chk("t1_idle_plus2", 32'(arb_idle), 32'd1);
    drain();

    // All four sources, two words each, from reset pointer.
    reset_dut();
    for (int unsigned k = 0; k < N; k++) begin
      src_push(k, 16'hA000 + 16'(k*16), 1'b0); exp_push(k, 16'hA000 + 16'(k*16));
      src_push(k, 16'hA001 + 16'(k*16), 1'b1); exp_push(k, 16'hA001 + 16'(k*16));
    end
    w_cnt  = 0;
    last_n = 0;
    for (int n = 1; n <= 40; n++) begin
      cyc();
      if (wr_en) begin
        w_cnt++;
        if (w_cnt == 8) begin
          last_n = n;
          break;
        end
      end
    end
    chk("t2_last_write_cycle", last_n, 32'd11);
    drain();

    // full held 5 cycles mid-packet on source 1; source 3 waits.
    reset_dut();
    for (int unsigned i = 0; i < 4; i++) begin
      src_push(1, 16'hB100 + 16'(i), i == 3); exp_push(1, 16'hB100 + 16'(i));
    end
    exp_push(3, 16'hB300);
    exp_push(3, 16'hB301);
    cyc();
    chk("t3_grant", 32'(grant), 32'd1);
    chk("t3_first_wr", 32'(wr_en), 32'd1);
    cyc();
    full = 1'b1;
    src_push(3, 16'hB300, 1'b0);
    src_push(3, 16'hB301, 1'b1);
    repeat (5) begin
      cyc();
      chk("t3_full_no_wr", 32'(wr_en), 32'd0);
      chk("t3_full_no_rd", 32'(src_rd_en), 32'd0);
    end
    full = 1'b0;
    drain();

    // Source 0 runs dry mid-packet; source 1 must not be served meanwhile.
    reset_dut();
    src_push(0, 16'hC000, 1'b0);
    src_push(1, 16'hC100, 1'b0);
    src_push(1, 16'hC101, 1'b1);
    exp_push(0, 16'hC000); exp_push(0, 16'hC001); exp_push(0, 16'hC002);
    exp_push(1, 16'hC100); exp_push(1, 16'hC101);
    cyc();
    chk("t4_grant", 32'(grant), 32'd0);
    repeat (4) begin
      cyc();
      chk("t4_grant_held", 32'(grant), 32'd0);
      chk("t4_no_rd", 32'(src_rd_en), 32'd0);
    end
    src_push(0, 16'hC001, 1'b0);
    src_push(0, 16'hC002, 1'b1);
    drain();

    // Reset in the middle of a packet.
    reset_dut();
    for (int unsigned i = 0; i < 4; i++) src_push(2, 16'hD200 + 16'(i), i == 3);
    exp_push(2, 16'hD200);
    cyc();
    chk("t5_grant", 32'(grant), 32'd2);
    cyc();
    RST = 1'b1;
    for (int k = 0; k < N; k++) sq[k].delete();
    exp_q.delete();
    cyc();
    chk("t5_rst_wr_en", 32'(wr_en), 32'd0);
    chk("t5_rst_rd_en", 32'(src_rd_en), 32'd0);
    chk("t5_rst_grant", 32'(grant), 32'd0);
    chk("t5_rst_arb_idle", 32'(arb_idle), 32'd1);
    chk("t5_rst_arb_err", 32'(arb_err), 32'd0);
    RST = 1'b0;
    cyc();
    src_push(3, 16'hD300, 1'b1);
    src_push(0, 16'hD000, 1'b1);
    exp_push(0, 16'hD000);
    exp_push(3, 16'hD300);
    cyc();
    chk("t5_first_grant", 32'(grant), 32'd0);
    drain();

    // Source 0 stalls empty mid-packet for 15 counted cycles.
    reset_dut();
    src_push(0, 16'hE000, 1'b0);
    exp_push(0, 16'hE000);
    cyc();
    chk("t6_first_wr", 32'(wr_en), 32'd1);
    repeat (15) cyc();
    chk("t6_err_before", 32'(arb_err), 32'd0);
    cyc();
`ifdef PKT_ARB_WATCHDOG_EN
    chk("t6_err_set", 32'(arb_err), 32'd1);
    src_push(0, 16'hE001, 1'b1);
    repeat (4) begin
      cyc();
      chk("t6_err_silent_wr", 32'(wr_en), 32'd0);
      chk("t6_err_sticky", 32'(arb_err), 32'd1);
    end
    reset_dut();
    chk("t6_err_cleared", 32'(arb_err), 32'd0);
`else
    chk("t6_err_stays_low", 32'(arb_err), 32'd0);
    chk("t6_grant_held", 32'(grant), 32'd0);
    src_push(0, 16'hE001, 1'b1);
    exp_push(0, 16'hE001);
    drain();
    chk("t6_err_after", 32'(arb_err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
